// File: rtl/sys_rsp_arbiter_if.sv
// Bundle between the result sources (register file / ALU), the response
// arbiter and the TX FIFO write port.
`timescale 1ns/1ps
interface sys_rsp_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   Rd_D;
    logic                    Rd_D_Valid;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_Valid;
    logic                    F_FULL;
    logic                    CLR_OVR;
    logic                    W_INC;
    logic [DATA_WIDTH-1:0]   WR_DATA;
    logic                    BUSY;
    logic                    RD_OVR;
    logic                    ALU_OVR;

    // Sources/FIFO side drives results and status, arbiter consumes them.
    modport master (
        output Rd_D, Rd_D_Valid, ALU_OUT, ALU_OUT_Valid, F_FULL, CLR_OVR,
        input  W_INC, WR_DATA, BUSY, RD_OVR, ALU_OVR
    );

    modport slave (
        input  Rd_D, Rd_D_Valid, ALU_OUT, ALU_OUT_Valid, F_FULL, CLR_OVR,
        output W_INC, WR_DATA, BUSY, RD_OVR, ALU_OVR
    );
endinterface

// File: rtl/sys_rsp_arbiter.sv
// Buffers one register-read byte and one 2-byte ALU result, then serializes
// them round-robin into the TX FIFO, one byte per non-full cycle.
`timescale 1ns/1ps
module sys_rsp_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_MSB_FIRST = 0
) (
    input  logic               CLK,
    input  logic               RST,
    sys_rsp_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SEND_RD, SEND_A0, SEND_A1} state_t;

    localparam bit FIRST_IDX  = (ALU_MSB_FIRST != 0);
    localparam bit SECOND_IDX = ~FIRST_IDX;

    state_t                  state_reg;
    logic                    rd_pending_reg;
    logic                    alu_pending_reg;
    logic                    last_grant_alu_reg;
    logic                    rd_ovr_reg;
    logic                    alu_ovr_reg;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic [2*DATA_WIDTH-1:0] alu_data_reg;

    logic                    push;
    logic                    rd_done;
    logic                    alu_done;
    logic                    rd_slot_free;
    logic                    alu_slot_free;
    logic [DATA_WIDTH-1:0]   alu_byte [2];
    logic [DATA_WIDTH-1:0]   wr_data_next;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_alu_byte
            assign alu_byte[gi] = alu_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign push     = (state_reg != IDLE) && !bus.F_FULL && !RST;
    assign rd_done  = push && (state_reg == SEND_RD);
    assign alu_done = push && (state_reg == SEND_A1);

    // A slot releasing its last byte this cycle can accept a new strobe now.
    assign rd_slot_free  = !rd_pending_reg  || rd_done;
    assign alu_slot_free = !alu_pending_reg || alu_done;

    always_comb begin
        wr_data_next = '0;
        case (state_reg)
            SEND_RD: wr_data_next = rd_data_reg;
            SEND_A0: wr_data_next = alu_byte[FIRST_IDX];
            SEND_A1: wr_data_next = alu_byte[SECOND_IDX];
            default: wr_data_next = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg          <= IDLE;
            rd_pending_reg     <= 1'b0;
            alu_pending_reg    <= 1'b0;
            last_grant_alu_reg <= 1'b1;
            rd_ovr_reg         <= 1'b0;
            alu_ovr_reg        <= 1'b0;
            rd_data_reg        <= '0;
            alu_data_reg       <= '0;
        end else begin
            if (bus.Rd_D_Valid && rd_slot_free) begin
                rd_data_reg    <= bus.Rd_D;
                rd_pending_reg <= 1'b1;
            end else if (rd_done) begin
                rd_pending_reg <= 1'b0;
            end

            if (bus.ALU_OUT_Valid && alu_slot_free) begin
                alu_data_reg    <= bus.ALU_OUT;
                alu_pending_reg <= 1'b1;
            end else if (alu_done) begin
                alu_pending_reg <= 1'b0;
            end

            // A drop in the same cycle as a clear request keeps the flag set.
            if (bus.Rd_D_Valid && !rd_slot_free)
                rd_ovr_reg <= 1'b1;
            else if (bus.CLR_OVR)
                rd_ovr_reg <= 1'b0;

            if (bus.ALU_OUT_Valid && !alu_slot_free)
                alu_ovr_reg <= 1'b1;
            else if (bus.CLR_OVR)
                alu_ovr_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (rd_pending_reg && (!alu_pending_reg || last_grant_alu_reg)) begin
                        state_reg          <= SEND_RD;
                        last_grant_alu_reg <= 1'b0;
                    end else if (alu_pending_reg) begin
                        state_reg          <= SEND_A0;
                        last_grant_alu_reg <= 1'b1;
                    end
                end
                SEND_RD: if (push) state_reg <= IDLE;
                SEND_A0: if (push) state_reg <= SEND_A1;
                SEND_A1: if (push) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.W_INC   = push;
    assign bus.WR_DATA = wr_data_next;
    assign bus.BUSY    = (state_reg != IDLE) || rd_pending_reg || alu_pending_reg;
    assign bus.RD_OVR  = rd_ovr_reg;
    assign bus.ALU_OVR = alu_ovr_reg;
endmodule

// File: tb/tb_sys_rsp_arbiter.sv
// Scoreboard bench: directed strobes queue expected FIFO bytes, a monitor per
// DUT pops and compares on every W_INC.
`timescale 1ns/1ps
module tb_sys_rsp_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_rsp_arbiter_if #(.DATA_WIDTH(8)) a_if ();
    sys_rsp_arbiter_if #(.DATA_WIDTH(8)) b_if ();

    sys_rsp_arbiter #(.DATA_WIDTH(8), .ALU_MSB_FIRST(0)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (a_if.slave)
    );

    sys_rsp_arbiter #(.DATA_WIDTH(8), .ALU_MSB_FIRST(1)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (b_if.slave)
    );

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        if (a_if.W_INC === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++;
                $display("FAIL a_push_unexpected: got byte %h expected no push", a_if.WR_DATA);
            end else begin
                $display("dut_a push %h (expect %h)", a_if.WR_DATA, exp_a[0]);
                chk("a_push", {8'h00, a_if.WR_DATA}, {8'h00, exp_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (b_if.W_INC === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++;
                $display("FAIL b_push_unexpected: got byte %h expected no push", b_if.WR_DATA);
            end else begin
                $display("dut_b push %h (expect %h)", b_if.WR_DATA, exp_b[0]);
                chk("b_push", {8'h00, b_if.WR_DATA}, {8'h00, exp_b.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_if.Rd_D = '0; a_if.Rd_D_Valid = 0; a_if.ALU_OUT = '0; a_if.ALU_OUT_Valid = 0;
        a_if.F_FULL = 0; a_if.CLR_OVR = 0;
        b_if.Rd_D = '0; b_if.Rd_D_Valid = 0; b_if.ALU_OUT = '0; b_if.ALU_OUT_Valid = 0;
        b_if.F_FULL = 0; b_if.CLR_OVR = 0;
        ticks(3);
        @(negedge clk);
        chk("rst_w_inc",   {15'd0, a_if.W_INC},   16'd0);
        chk("rst_wr_data", {8'd0, a_if.WR_DATA},  16'd0);
        chk("rst_busy",    {15'd0, a_if.BUSY},    16'd0);
        chk("rst_rd_ovr",  {15'd0, a_if.RD_OVR},  16'd0);
        chk("rst_alu_ovr", {15'd0, a_if.ALU_OVR}, 16'd0);
        tick();
        rst = 1'b0;
        ticks(2);

        // Single read: strobe in cycle N, push in N+2, BUSY low by N+3.
        a_if.Rd_D = 8'h5A; a_if.Rd_D_Valid = 1; exp_a.push_back(8'h5A);
        @(negedge clk); chk("rd_busy_n0", {15'd0, a_if.BUSY}, 16'd0);
        tick(); a_if.Rd_D_Valid = 0;
        @(negedge clk); chk("rd_busy_n1", {15'd0, a_if.BUSY}, 16'd1);
        chk("rd_winc_n1", {15'd0, a_if.W_INC}, 16'd0);
        tick();
        @(negedge clk); chk("rd_winc_n2", {15'd0, a_if.W_INC}, 16'd1);
        chk("rd_busy_n2", {15'd0, a_if.BUSY}, 16'd1);
        tick();
        @(negedge clk); chk("rd_winc_n3", {15'd0, a_if.W_INC}, 16'd0);
        chk("rd_busy_n3", {15'd0, a_if.BUSY}, 16'd0);
        ticks(2);

        // ALU byte order on both instances.
        a_if.ALU_OUT = 16'h1234; a_if.ALU_OUT_Valid = 1;
        b_if.ALU_OUT = 16'h1234; b_if.ALU_OUT_Valid = 1;
        exp_a.push_back(8'h34); exp_a.push_back(8'h12);
        exp_b.push_back(8'h12); exp_b.push_back(8'h34);
        tick(); a_if.ALU_OUT_Valid = 0; b_if.ALU_OUT_Valid = 0;
        tick();
        @(negedge clk); chk("alu_a0_winc", {15'd0, a_if.W_INC}, 16'd1);
        tick();
        @(negedge clk); chk("alu_a1_winc", {15'd0, a_if.W_INC}, 16'd1);
        ticks(3);

        // Simultaneous pair: last grant was ALU, so RD goes first.
        a_if.Rd_D = 8'hA1; a_if.Rd_D_Valid = 1;
        a_if.ALU_OUT = 16'hBEEF; a_if.ALU_OUT_Valid = 1;
        exp_a.push_back(8'hA1); exp_a.push_back(8'hEF); exp_a.push_back(8'hBE);
        tick(); a_if.Rd_D_Valid = 0; a_if.ALU_OUT_Valid = 0;
        ticks(8);
        chk("pair1_ovr", {14'd0, a_if.RD_OVR, a_if.ALU_OVR}, 16'd0);

        // Lone read leaves last grant on RD, so the next pair is ALU first.
        a_if.Rd_D = 8'h77; a_if.Rd_D_Valid = 1; exp_a.push_back(8'h77);
        tick(); a_if.Rd_D_Valid = 0;
        ticks(4);
        a_if.Rd_D = 8'hC3; a_if.Rd_D_Valid = 1;
        a_if.ALU_OUT = 16'h5678; a_if.ALU_OUT_Valid = 1;
        exp_a.push_back(8'h78); exp_a.push_back(8'h56); exp_a.push_back(8'hC3);
        tick(); a_if.Rd_D_Valid = 0; a_if.ALU_OUT_Valid = 0;
        ticks(8);

        // FIFO-full stall for 5 cycles while in SEND_A1.
        a_if.ALU_OUT = 16'hCAFE; a_if.ALU_OUT_Valid = 1;
        exp_a.push_back(8'hFE); exp_a.push_back(8'hCA);
        tick(); a_if.ALU_OUT_Valid = 0;
        tick();
        tick(); a_if.F_FULL = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_winc", {15'd0, a_if.W_INC}, 16'd0);
            chk("stall_data", {8'd0, a_if.WR_DATA}, 16'h00CA);
            tick();
        end
        a_if.F_FULL = 0;
        @(negedge clk); chk("stall_release", {15'd0, a_if.W_INC}, 16'd1);
        ticks(3);

        // Overrun: second strobe dropped; clear loses to a simultaneous drop.
        a_if.F_FULL = 1;
        a_if.Rd_D = 8'h11; a_if.Rd_D_Valid = 1; exp_a.push_back(8'h11);
        tick(); a_if.Rd_D = 8'h22;
        tick(); a_if.Rd_D_Valid = 0;
        @(negedge clk); chk("ovr_set", {15'd0, a_if.RD_OVR}, 16'd1);
        tick(); a_if.Rd_D = 8'h33; a_if.Rd_D_Valid = 1; a_if.CLR_OVR = 1;
        tick(); a_if.Rd_D_Valid = 0; a_if.CLR_OVR = 0;
        @(negedge clk); chk("ovr_set_beats_clr", {15'd0, a_if.RD_OVR}, 16'd1);
        tick(); a_if.CLR_OVR = 1;
        tick(); a_if.CLR_OVR = 0;
        @(negedge clk); chk("ovr_cleared", {15'd0, a_if.RD_OVR}, 16'd0);
        chk("ovr_alu_clean", {15'd0, a_if.ALU_OVR}, 16'd0);
        chk("ovr_full_no_push", {15'd0, a_if.W_INC}, 16'd0);
        tick(); a_if.F_FULL = 0;
        ticks(4);

        // Reset during SEND_A1 discards the second byte and a same-cycle strobe.
        a_if.ALU_OUT = 16'hDEAD; a_if.ALU_OUT_Valid = 1; exp_a.push_back(8'hAD);
        tick(); a_if.ALU_OUT_Valid = 0;
        tick();
        tick(); rst = 1; a_if.Rd_D = 8'h99; a_if.Rd_D_Valid = 1;
        @(negedge clk); chk("rst_mid_winc", {15'd0, a_if.W_INC}, 16'd0);
        tick(); rst = 0; a_if.Rd_D_Valid = 0;
        @(negedge clk);
        chk("post_rst_winc", {15'd0, a_if.W_INC}, 16'd0);
        chk("post_rst_data", {8'd0, a_if.WR_DATA}, 16'd0);
        chk("post_rst_busy", {15'd0, a_if.BUSY}, 16'd0);
        ticks(6);

        chk("a_queue_drained", exp_a.size(), 16'd0);
        chk("b_queue_drained", exp_b.size(), 16'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
